// File: rtl/bus_slave_responder.sv
// Bus slave responder: wait-stated reads/writes to a small word memory, ERROR for
// unmapped addresses, and SPLIT/RETRY handling with a timed split release.
module bus_slave_responder #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 64,
    parameter int WAIT_CYCLES  = 2,
    parameter int SPLIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              split_en,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic [1:0]        response,
    output logic              split
);
    localparam int CNT_MAX = (WAIT_CYCLES > SPLIT_CYCLES) ? WAIT_CYCLES : SPLIT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;
    localparam logic [1:0] RSP_RETRY = 2'b10;
    localparam logic [1:0] RSP_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2, S_SPL1, S_SPL2, S_HOLD
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_addr;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_pend;
    logic              r_ready;
    logic [1:0]        r_resp;
    logic              r_split;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_unmapped;
    logic              w_to_split;
    logic              w_idle_go;
    logic              w_done_entry;
    logic [IDX_W-1:0]  w_idx;
    logic              w_acc_wr;
    logic [DATA_W-1:0] w_acc_data;
    logic              w_mem_we;

    assign w_unmapped = ({1'b0, addr_in} >= LIMIT);
    assign w_to_split = split_en && !r_pend;
    assign w_idle_go  = (r_state == S_IDLE) && sel && !w_unmapped && !w_to_split;

    // The DONE-entry access uses live inputs when skipping WAIT, latched values otherwise.
    assign w_done_entry = (w_idle_go && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_idx      = (r_state == S_IDLE) ? addr_in[IDX_W-1:0] : r_addr;
    assign w_acc_wr   = (r_state == S_IDLE) ? read_write : r_wr;
    assign w_acc_data = (r_state == S_IDLE) ? data_in : r_wdata;
    assign w_mem_we   = rst && w_done_entry && w_acc_wr;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_idx] <= w_acc_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
            r_resp  <= RSP_OKAY;
            r_split <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_split <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_resp  <= RSP_OKAY;
                    if (sel) begin
                        r_addr  <= addr_in[IDX_W-1:0];
                        r_wr    <= read_write;
                        r_wdata <= data_in;
                        if (w_unmapped) begin
                            r_state <= S_ERR1;
                            r_ready <= 1'b0;
                            r_resp  <= RSP_ERROR;
                        end else if (w_to_split) begin
                            r_state <= S_SPL1;
                            r_ready <= 1'b0;
                            r_resp  <= RSP_SPLIT;
                        end else begin
                            r_pend <= 1'b0;
                            if (WAIT_CYCLES == 0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_WAIT;
                                r_ready <= 1'b0;
                                r_cnt   <= CNT_W'(WAIT_CYCLES);
                            end
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_OKAY;
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_ERROR;
                end
                S_ERR2: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_OKAY;
                end
                S_SPL1: begin
                    r_state <= S_SPL2;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_SPLIT;
                end
                S_SPL2: begin
                    r_state <= S_HOLD;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_OKAY;
                    r_cnt   <= CNT_W'(SPLIT_CYCLES);
                end
                S_HOLD: begin
                    // A master knocking during HOLD is told to retry later; nothing is latched.
                    r_ready <= 1'b1;
                    r_resp  <= sel ? RSP_RETRY : RSP_OKAY;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_split <= 1'b1;
                        r_pend  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_resp  <= RSP_OKAY;
                end
            endcase
            if (w_done_entry && !w_acc_wr) r_dout <= r_mem[w_idx];
        end
    end

    assign data_out = r_dout;
    assign ready    = r_ready;
    assign response = r_resp;
    assign split    = r_split;
endmodule
